counter_cmd_arbiter: RTL

COUNTER_CMD_ARBITER -- requirements
Module: counter_cmd_arbiter

---
 rtl/counter_cmd_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/counter_cmd_arbiter.sv
// Shared 8-bit counter driven by two handshaked command requesters (A, B)
// and a free-running divider that produces autocount ticks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate: host requests first (round-robin), then ticks
// EXEC_A  | apply a_cmd to count, pulse a_ack
// EXEC_B  | apply b_cmd to count, pulse b_ack
// EXEC_T  | increment count for a pending divider tick, no ack
module counter_cmd_arbiter #(
  parameter int                   DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_LOAD  = DIV_WIDTH'(24'h100000)
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic [1:0] a_cmd,
  input  logic       b_req,
  input  logic [1:0] b_cmd,
  input  logic       autocount,
  output logic       a_ack,
  output logic       b_ack,
  output logic [7:0] count,
  output logic       eq00,
  output logic       eqFF,
  output logic       wrap,
  output logic       tick_drop
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC_A = 2'd1;
  localparam logic [1:0] S_EXEC_B = 2'd2;
  localparam logic [1:0] S_EXEC_T = 2'd3;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_UP    = 2'b01;
  localparam logic [1:0] CMD_DOWN  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic                 last_grant;   // 1 = B was granted last
  logic                 tick_pend;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;
  logic [1:0]           exec_cmd;
  logic [7:0]           count_nxt;
  logic                 wrap_nxt;

  assign tick = (div_cnt == '0);

  // Acks are tied to the EXEC cycle itself; a reset landing in that cycle
  // aborts the command, so the ack must not be seen either.
  assign a_ack = (state == S_EXEC_A) && !reset;
  assign b_ack = (state == S_EXEC_B) && !reset;

  // Arbitration: host requests beat ticks; A/B alternate when both wait.
  // A tick is only taken while autocount is still enabled, so dropping
  // autocount with a tick pending never produces an increment.
  always_comb begin
    state_nxt = S_IDLE;
    if (state == S_IDLE) begin
      if (a_req && b_req)             state_nxt = last_grant ? S_EXEC_A : S_EXEC_B;
      else if (a_req)                 state_nxt = S_EXEC_A;
      else if (b_req)                 state_nxt = S_EXEC_B;
      else if (tick_pend && autocount) state_nxt = S_EXEC_T;
      else                            state_nxt = S_IDLE;
    end
  end

  // Command decode and modulo-256 arithmetic for the EXEC cycle.
  always_comb begin
    exec_cmd  = CMD_NOP;
    count_nxt = count;
    wrap_nxt  = 1'b0;
    case (state)
      S_EXEC_A: exec_cmd = a_cmd;
      S_EXEC_B: exec_cmd = b_cmd;
      S_EXEC_T: exec_cmd = CMD_UP;
      default:  exec_cmd = CMD_NOP;
    endcase
    case (exec_cmd)
      CMD_UP: begin
        count_nxt = count + 8'd1;
        wrap_nxt  = (count == 8'hFF);
      end
      CMD_DOWN: begin
        count_nxt = count - 8'd1;
        wrap_nxt  = (count == 8'h00);
      end
      CMD_CLEAR: count_nxt = 8'h00;
      default:   count_nxt = count;
    endcase
  end

  // FSM, counter, flags and grant history.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= 8'h00;
      eq00       <= 1'b1;
      eqFF       <= 1'b0;
      wrap       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      wrap  <= wrap_nxt;
      eq00  <= (count == 8'h00);
      eqFF  <= (count == 8'hFF);
      if (state == S_EXEC_A) last_grant <= 1'b0;
      if (state == S_EXEC_B) last_grant <= 1'b1;
    end
  end

  // Divider and tick collapsing. A fresh tick arriving in the EXEC_T cycle
  // re-arms tick_pend rather than counting as a drop, since the old one is
  // being consumed in that same cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div_cnt   <= DIV_LOAD;
      tick_pend <= 1'b0;
      tick_drop <= 1'b0;
    end else begin
      div_cnt   <= tick ? DIV_LOAD : div_cnt - 1'b1;
      tick_drop <= 1'b0;
      if (!autocount) begin
        tick_pend <= 1'b0;
      end else if (tick) begin
        tick_pend <= 1'b1;
        tick_drop <= tick_pend && (state != S_EXEC_T);
      end else if (state == S_EXEC_T) begin
        tick_pend <= 1'b0;
      end
    end
  end

endmodule
